// File: rtl/multiply_divide_unit.sv
// Multiply/divide unit: single-cycle MUL/MULU into {hi,lo}, multi-cycle restoring DIV/DIVU.
// Division hardware is built only when MDU_DIV_EN is defined; otherwise DIV/DIVU are ignored.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_OP_MUL
`define ALU_OP_MUL 4'h8
`endif
`ifndef ALU_OP_MULU
`define ALU_OP_MULU 4'h9
`endif
`ifndef ALU_OP_DIV
`define ALU_OP_DIV 4'hA
`endif
`ifndef ALU_OP_DIVU
`define ALU_OP_DIVU 4'hB
`endif

module multiply_divide_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     start,
  input  logic [`ALU_OP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]    rs,
  input  logic [DATA_WIDTH-1:0]    rt,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    hi,
  output logic [DATA_WIDTH-1:0]    lo
);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0] hi_reg, lo_reg;
  logic                  done_reg;

  logic                        can_accept;
  logic                        mul_accept;
  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic [2*DATA_WIDTH-1:0]     prod_u;

  assign can_accept = (state_reg == IDLE) && start && !stall;
  assign mul_accept = can_accept && ((op == `ALU_OP_MUL) || (op == `ALU_OP_MULU));
  assign prod_s     = $signed(rs) * $signed(rt);
  assign prod_u     = {{DATA_WIDTH{1'b0}}, rs} * {{DATA_WIDTH{1'b0}}, rt};

`ifdef MDU_DIV_EN
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  logic [CW-1:0]         cnt_reg;
  logic [DATA_WIDTH-1:0] rem_reg, quo_reg, dvs_reg;
  logic                  neg_q_reg, neg_r_reg, dbz_reg;

  logic                  div_accept;
  logic                  is_signed_div;
  logic [DATA_WIDTH-1:0] rs_mag, rt_mag;
  logic [DATA_WIDTH:0]   rem_shift, rem_diff;
  logic [DATA_WIDTH-1:0] quo_fixed, rem_fixed;

  assign div_accept    = can_accept && ((op == `ALU_OP_DIV) || (op == `ALU_OP_DIVU));
  assign is_signed_div = (op == `ALU_OP_DIV);
  assign rs_mag = (is_signed_div && rs[DATA_WIDTH-1]) ? -rs : rs;
  assign rt_mag = (is_signed_div && rt[DATA_WIDTH-1]) ? -rt : rt;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign rem_shift = {rem_reg, quo_reg[DATA_WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, dvs_reg};

  assign quo_fixed = neg_q_reg ? -quo_reg : quo_reg;
  assign rem_fixed = neg_r_reg ? -rem_reg : rem_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
`ifdef MDU_DIV_EN
    case (state_reg)
      IDLE: begin
        if (div_accept) begin
          state_next = (rt == '0) ? FIX : DIV;
        end
      end
      DIV: begin
        if (cnt_reg == CW'(DATA_WIDTH - 1)) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
`else
    state_next = IDLE;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
`ifdef MDU_DIV_EN
      cnt_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      dbz_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (mul_accept) begin
        {hi_reg, lo_reg} <= (op == `ALU_OP_MUL) ? prod_s : prod_u;
        done_reg         <= 1'b1;
      end
`ifdef MDU_DIV_EN
      case (state_reg)
        IDLE: begin
          if (div_accept) begin
            cnt_reg   <= '0;
            dbz_reg   <= (rt == '0);
            neg_q_reg <= is_signed_div && (rs[DATA_WIDTH-1] ^ rt[DATA_WIDTH-1]);
            neg_r_reg <= is_signed_div && rs[DATA_WIDTH-1];
            dvs_reg   <= rt_mag;
            // Divide-by-zero skips DIV; preload the architectural result.
            if (rt == '0) begin
              rem_reg <= rs;
              quo_reg <= '1;
            end else begin
              rem_reg <= '0;
              quo_reg <= rs_mag;
            end
          end
        end
        DIV: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (!rem_diff[DATA_WIDTH]) begin
            rem_reg <= rem_diff[DATA_WIDTH-1:0];
            quo_reg <= {quo_reg[DATA_WIDTH-2:0], 1'b1};
          end else begin
            rem_reg <= rem_shift[DATA_WIDTH-1:0];
            quo_reg <= {quo_reg[DATA_WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          lo_reg   <= dbz_reg ? quo_reg : quo_fixed;
          hi_reg   <= dbz_reg ? rem_reg : rem_fixed;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
`endif
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Scoreboard bench for multiply_divide_unit; expectations adapt to whether MDU_DIV_EN is defined.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_OP_MUL
`define ALU_OP_MUL 4'h8
`endif
`ifndef ALU_OP_MULU
`define ALU_OP_MULU 4'h9
`endif
`ifndef ALU_OP_DIV
`define ALU_OP_DIV 4'hA
`endif
`ifndef ALU_OP_DIVU
`define ALU_OP_DIVU 4'hB
`endif

module tb_multiply_divide_unit;

  logic                     clk;
  logic                     rst_n;
  logic                     stall;
  logic                     start;
  logic [`ALU_OP_WIDTH-1:0] op;
  logic [31:0]              rs;
  logic [31:0]              rt;
  logic                     busy;
  logic                     done;
  logic [31:0]              hi;
  logic [31:0]              lo;

  multiply_divide_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy_cycles;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          busy_cnt = 0;
  logic [31:0] last_hi = 32'h0;
  logic [31:0] last_lo = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
    end else begin
      $display("[TB] ok %s = 0x%08h", name, act);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: actual hi=0x%08h lo=0x%08h required no done", hi, lo);
        end else begin
          e = sb_q.pop_front();
          check({e.name, ".hi"}, hi, e.hi);
          check({e.name, ".lo"}, lo, e.lo);
          check({e.name, ".busy"}, 32'(busy_cnt), 32'(e.busy_cycles));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic push(input string name, input logic [31:0] h, input logic [31:0] l, input int bc);
    exp_t e;
    e.name = name; e.hi = h; e.lo = l; e.busy_cycles = bc;
    sb_q.push_back(e);
    last_hi = h;
    last_lo = l;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic stl);
    @(negedge clk);
    op = o; rs = a; rt = b; start = 1'b1; stall = stl;
    @(negedge clk);
    start = 1'b0; stall = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL busy_timeout: actual busy=1 after %0d cycles required 0", n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_ignored(input string name, input logic [3:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic stl);
    issue(o, a, b, stl);
    check({name, ".busy"}, {31'b0, busy}, 32'h0);
    settle();
    check({name, ".hi_kept"}, hi, last_hi);
    check({name, ".lo_kept"}, lo, last_lo);
  endtask

  task automatic div_case(input string name, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                          input int bc);
`ifdef MDU_DIV_EN
    push(name, h, l, bc);
    issue(o, a, b, 1'b0);
    settle();
`else
    expect_ignored(name, o, a, b, 1'b0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; start = 1'b0; op = '0; rs = '0; rt = '0;
    repeat (3) @(negedge clk);
    check("reset.hi", hi, 32'h0);
    check("reset.lo", lo, 32'h0);
    check("reset.busy", {31'b0, busy}, 32'h0);
    check("reset.done", {31'b0, done}, 32'h0);
    #2 rst_n = 1'b1;

    push("mul_neg2x3", 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
    issue(`ALU_OP_MUL, 32'hFFFFFFFE, 32'd3, 1'b0);
    settle();

    push("mulu_max_x2", 32'h00000001, 32'hFFFFFFFE, 0);
    issue(`ALU_OP_MULU, 32'hFFFFFFFF, 32'd2, 1'b0);
    settle();

    expect_ignored("bad_op", 4'h0, 32'd5, 32'd5, 1'b0);
    expect_ignored("mul_stalled", `ALU_OP_MUL, 32'd7, 32'd7, 1'b1);

    div_case("div_m7_2",    `ALU_OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    div_case("divu_100_0",  `ALU_OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1);
    div_case("div_ovf",     `ALU_OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
    div_case("div_m8_m3",   `ALU_OP_DIV,  32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h2, 33);
    div_case("divu_big_16", `ALU_OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 33);

    // DIVU 100/7 with a MUL start at cycle 5 and stall toggling throughout.
`ifdef MDU_DIV_EN
    push("divu_100_7", 32'd2, 32'd14, 33);
`endif
    issue(`ALU_OP_DIVU, 32'd100, 32'd7, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      if (c == 5) begin
`ifndef MDU_DIV_EN
        push("mul_c5", 32'd0, 32'd9, 0);
`endif
        op = `ALU_OP_MUL; rs = 32'd3; rt = 32'd3; start = 1'b1; stall = 1'b0;
      end else begin
        start = 1'b0; stall = ~stall;
      end
      @(negedge clk);
    end
    start = 1'b0; stall = 1'b0;
    settle();

    // Asynchronous reset mid-division.
`ifndef MDU_DIV_EN
    push("mul_pre_rst", 32'd0, 32'd42, 0);
    issue(`ALU_OP_MUL, 32'd6, 32'd7, 1'b0);
`endif
    issue(`ALU_OP_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.busy", {31'b0, busy}, 32'h0);
    check("rst_mid.done", {31'b0, done}, 32'h0);
    check("rst_mid.hi", hi, 32'h0);
    check("rst_mid.lo", lo, 32'h0);
    last_hi = 32'h0; last_lo = 32'h0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    push("mul_after_rst", 32'd0, 32'd30, 0);
    issue(`ALU_OP_MUL, 32'd5, 32'd6, 1'b0);
    settle();

    repeat (40) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multiply_divide_unit.md
MULTIPLY_DIVIDE_UNIT -- requirements
Module: multiply_divide_unit

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 32, width of operands, hi and lo.
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: stall  input  1  pipeline stall; while high, no new operation is accepted.
REQ-005 SHALL have port: start  input  1  request to begin the operation in op.
REQ-006 SHALL have port: op  input  `ALU_OP_WIDTH  operation code; only ALU_OP_MUL, ALU_OP_MULU, ALU_OP_DIV and ALU_OP_DIVU are acted on.
REQ-007 SHALL have port: rs  input  DATA_WIDTH  first operand: multiplicand or dividend.
REQ-008 SHALL have port: rt  input  DATA_WIDTH  second operand: multiplier or divisor.
REQ-009 SHALL have port: busy  output  1  a division is in progress; the decode stage stalls MFHI/MFLO and new MUL/DIV ops while high.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; hi and lo were updated at the preceding edge.
REQ-011 SHALL have port: hi  output  DATA_WIDTH  registered HI (upper product half or remainder); consumed by the ALU's MFHI path.
REQ-012 SHALL have port: lo  output  DATA_WIDTH  registered LO (lower product half or quotient); consumed by the ALU's MFLO path.

Function
REQ-013 SHALL implement FSM states IDLE, DIV and FIX; an operation is accepted only in IDLE, on a rising edge with start=1, stall=0 and op in the REQ-006 set; any other op is ignored.
REQ-014 SHALL, on accepting MUL/MULU, write {hi,lo} = signed/unsigned rs*rt (2*DATA_WIDTH bits) at that edge, stay in IDLE, keep busy=0, and drive done=1 for the following cycle.
REQ-015 SHALL, on accepting DIV/DIVU with rt!=0, latch the operand magnitudes (absolute values for DIV, raw values for DIVU) and the sign flags, clear a 6-bit iteration counter, enter DIV and raise busy.
REQ-016 SHALL in DIV perform one restoring shift-subtract step per cycle over DATA_WIDTH cycles, then enter FIX.
REQ-017 SHALL in FIX apply signs (quotient negated when operand signs differ; remainder takes the dividend's sign), write lo=quotient and hi=remainder, return to IDLE, drop busy, and pulse done.
REQ-018 SHALL give busy high for exactly DATA_WIDTH+1 cycles per division: accept at edge 0, hi/lo valid after edge 33 (for DATA_WIDTH=32).
REQ-019 SHALL on divide by zero (rt=0) go directly from IDLE to FIX, then write lo=all ones and hi=rs (busy high for 1 cycle).
REQ-020 SHALL on signed overflow (rs=0x80000000, rt=0xFFFFFFFF, DIV) produce lo=0x80000000, hi=0.
REQ-021 SHALL ignore start and stall while busy; an in-flight division is neither paused nor restarted by them.
REQ-022 SHALL hold hi and lo unchanged except at a MUL accept edge or a FIX edge; partial results are never visible.

Reset
REQ-023 SHALL on rst_n=0, immediately and regardless of clk, force IDLE, hi=0, lo=0, busy=0, done=0 and clear the counter and working registers.
REQ-024 SHALL on reset during DIV or FIX abort the division, leaving hi/lo=0 and producing no done pulse.

Configuration
REQ-025 SHALL, when macro MDU_DIV_EN is defined, implement division per REQ-015..REQ-021.
REQ-026 SHALL, when MDU_DIV_EN is undefined, omit DIV/FIX logic, treat DIV/DIVU as ignored ops (busy stays 0, hi/lo unchanged, no done), and keep MUL/MULU behaviour identical.

Verification
REQ-027 SHALL cover: MUL rs=0xFFFFFFFE(-2), rt=3 -> after 1 edge hi=0xFFFFFFFF, lo=0xFFFFFFFA, done 1 cycle, busy never 1.
REQ-028 SHALL cover: MULU rs=0xFFFFFFFF, rt=2 -> hi=1, lo=0xFFFFFFFE.
REQ-029 SHALL cover: DIV rs=-7, rt=2 -> busy 33 cycles, then lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1), done 1 cycle.
REQ-030 SHALL cover: DIVU rs=100, rt=0 -> busy 1 cycle, lo=0xFFFFFFFF, hi=100; then DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-031 SHALL cover: DIVU 100/7 started, start with MUL pulsed at cycle 5 and stall toggled -> ignored; lo=14, hi=2 at cycle 33.
REQ-032 SHALL cover: rst_n low at cycle 10 of a DIV -> busy=0, hi=lo=0 immediately, no done; next MUL accepted normally.
